// File: rtl/pll_meter.sv
// Measures the averaged period of sig_a and the averaged sig_a-rise to sig_b-rise delay,
// both in clk_50 cycles, over 2^AVG_LOG2 consecutive sig_a periods per start request.
module pll_meter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000,
    parameter int unsigned AVG_LOG2       = 2
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic        sig_a,
    input  logic        sig_b,
    input  logic        start,
    output logic        busy,
    output logic        valid,
    output logic        timeout,
    output logic [15:0] period,
    output logic [15:0] phase,
    output logic [1:0]  state_dbg_o
);

    localparam int unsigned AW = 16 + AVG_LOG2;
    localparam int unsigned NW = AVG_LOG2 + 1;
    localparam logic [NW-1:0] LAST_IDX = NW'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     a_sync_q, b_sync_q;
    logic [15:0]    tmo_q, tmo_d;
    logic [15:0]    per_q, per_d;
    logic [15:0]    ph_q, ph_d;
    logic           got_b_q, got_b_d;
    logic [NW-1:0]  n_q, n_d;
    logic [AW-1:0]  accp_q, accp_d;
    logic [AW-1:0]  accph_q, accph_d;
    logic [15:0]    period_q, period_d;
    logic [15:0]    phase_q, phase_d;

    logic           ea, eb, tmo_hit;
    logic [15:0]    ph_smp;
    logic [AW-1:0]  accp_sum, accph_sum;

    // Bit 0 and 1 are the two synchronizer flops, bit 2 is the edge-detector history.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_sync_q <= {a_sync_q[1:0], sig_a};
            b_sync_q <= {b_sync_q[1:0], sig_b};
        end
    end

    assign ea = a_sync_q[1] & ~a_sync_q[2];
    assign eb = b_sync_q[1] & ~b_sync_q[2];

    // A period without any sig_b rise contributes its full length as the phase sample.
    assign ph_smp    = got_b_q ? ph_q : per_q;
    assign accp_sum  = accp_q + AW'(per_q);
    assign accph_sum = accph_q + AW'(ph_smp);
    assign tmo_hit   = (tmo_q == TIMEOUT_CYCLES);

    always_comb begin
        state_d  = state_q;
        tmo_d    = '0;
        per_d    = per_q;
        ph_d     = ph_q;
        got_b_d  = got_b_q;
        n_d      = n_q;
        accp_d   = accp_q;
        accph_d  = accph_q;
        period_d = period_q;
        phase_d  = phase_q;
        busy     = 1'b0;
        valid    = 1'b0;
        timeout  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = ARM;
            end
            ARM: begin
                busy  = 1'b1;
                tmo_d = tmo_q + 16'd1;
                if (tmo_hit) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else if (ea) begin
                    state_d = MEAS;
                    tmo_d   = '0;
                    per_d   = 16'd1;
                    got_b_d = eb;
                    ph_d    = '0;
                    n_d     = '0;
                    accp_d  = '0;
                    accph_d = '0;
                end
            end
            MEAS: begin
                busy  = 1'b1;
                tmo_d = tmo_q + 16'd1;
                per_d = per_q + 16'd1;
                if (tmo_hit) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else if (ea) begin
                    // An eb coinciding with this ea belongs to the period being opened.
                    tmo_d   = '0;
                    per_d   = 16'd1;
                    got_b_d = eb;
                    ph_d    = '0;
                    accp_d  = accp_sum;
                    accph_d = accph_sum;
                    n_d     = n_q + NW'(1);
                    if (n_q == LAST_IDX) begin
                        state_d  = DONE;
                        period_d = accp_sum[AW-1:AVG_LOG2];
                        phase_d  = accph_sum[AW-1:AVG_LOG2];
                    end
                end else if (eb && !got_b_q) begin
                    got_b_d = 1'b1;
                    ph_d    = per_q;
                end
            end
            DONE: begin
                valid   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q  <= IDLE;
            tmo_q    <= '0;
            per_q    <= '0;
            ph_q     <= '0;
            got_b_q  <= 1'b0;
            n_q      <= '0;
            accp_q   <= '0;
            accph_q  <= '0;
            period_q <= '0;
            phase_q  <= '0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            per_q    <= per_d;
            ph_q     <= ph_d;
            got_b_q  <= got_b_d;
            n_q      <= n_d;
            accp_q   <= accp_d;
            accph_q  <= accph_d;
            period_q <= period_d;
            phase_q  <= phase_d;
        end
    end

    assign period      = period_q;
    assign phase       = phase_q;
    assign state_dbg_o = state_q;

endmodule

// File: doc/pll_meter.md
PLL_METER -- requirements
Module: pll_meter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd2000; it is the maximum number of clk_50 cycles allowed between successive sig_a rising edges, and it SHALL be at most 65535.
REQ-002 SHALL have parameter AVG_LOG2, default 2; each measurement averages 2^AVG_LOG2 periods.
REQ-003 clk_50  in  1  system clock; one clock domain; all logic on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 sig_a  in  1  reference signal (e.g. PLL feedback); asynchronous.
REQ-006 sig_b  in  1  compared signal (e.g. PLL output); asynchronous.
REQ-007 start  in  1  single-cycle request to begin one measurement.
REQ-008 busy  out  1  high while a measurement is in progress.
REQ-009 valid  out  1  one-cycle pulse when period and phase are updated.
REQ-010 timeout  out  1  one-cycle pulse when a measurement is aborted.
REQ-011 period  out  16  averaged sig_a period, in clk_50 cycles.
REQ-012 phase  out  16  averaged delay from a sig_a rise to a sig_b rise, in clk_50 cycles.

Function
REQ-013 SHALL pass each of sig_a and sig_b through its own two-flop synchronizer followed by a rising-edge detector; the detector output is a one-cycle strobe (ea, eb); both inputs SHALL have identical synchronizer latency.
REQ-014 State machine SHALL have states IDLE, ARM, MEAS and DONE.
REQ-015 IDLE: start=1 -> ARM; otherwise stay; busy=0.
REQ-016 ARM: first ea -> MEAS, clearing the accumulators and starting the first period; eb in ARM is ignored; busy=1.
REQ-017 MEAS: each ea closes one period; after the 2^AVG_LOG2-th closing ea -> DONE; busy=1.
REQ-018 DONE: lasts one cycle; valid=1; period and phase update in this cycle; -> IDLE; busy=0.
REQ-019 Period sample: the number of cycles between consecutive ea strobes (strobes at cycles 10 and 410 give 400).
REQ-020 Phase sample: the cycles from an ea to the first eb in the same or a later cycle; eb in the same cycle as ea gives 0.
REQ-021 Only the first eb after each ea counts; later eb strobes in that period are ignored.
REQ-022 If no eb occurs before the next ea, the phase sample SHALL equal that period's period sample.
REQ-023 Accumulators SHALL be 16+AVG_LOG2 bits wide and SHALL NOT overflow.
REQ-024 period = period_accum >> AVG_LOG2; phase = phase_accum >> AVG_LOG2 (truncating).
REQ-025 Latency: valid SHALL assert exactly one cycle after the final closing ea strobe.
REQ-026 period and phase SHALL hold their values between valid pulses.
REQ-027 Timeout counter: clears on entry to ARM and on every ea; increments every cycle in ARM and MEAS.
REQ-028 On reaching TIMEOUT_CYCLES, the block SHALL pulse timeout for one cycle, go to IDLE, and leave period and phase unchanged; valid SHALL NOT assert.
REQ-029 start while busy=1 or in DONE SHALL be ignored; it is not queued.
REQ-030 start in IDLE in the same cycle as an ea: the ea is not used, and ARM waits for the next ea.
REQ-031 ea in the same cycle as the timeout threshold: the timeout takes priority.
REQ-032 Simultaneous ea and eb in MEAS: the eb belongs to the period that ea opens, giving phase sample 0.

Reset
REQ-033 While rst=1: state=IDLE; busy=0, valid=0, timeout=0; period=0, phase=0.
REQ-034 While rst=1, all counters, accumulators and synchronizer flops SHALL be cleared.
REQ-035 rst during ARM or MEAS SHALL abort the measurement with no valid or timeout pulse.
REQ-036 start SHALL be ignored in the cycle rst is high.

Verification
REQ-037 sig_a period 400 cycles, sig_b = sig_a delayed 100 cycles, start -> one valid pulse; period=400, phase=100; busy low after valid.
REQ-038 sig_a period 400, sig_b delays 100, 101, 102, 103 in successive periods -> phase=101 (406>>2), period=400.
REQ-039 sig_a held low after start -> timeout pulse 2000 cycles after ARM entry; no valid; period and phase keep prior values.
REQ-040 sig_a period 400, sig_b held low -> phase=400, period=400.
REQ-041 rst asserted mid-MEAS -> next cycle busy=0, period=0, phase=0; no valid; a new start then measures normally.
REQ-042 Second start pulsed during busy -> exactly one valid pulse, then IDLE; sig_a and sig_b rising in the same cycle -> phase=0.
